pc_sequencer: RTL

Program-counter sequencer and branch-flush controller for the pipelined core. Owns the PC register and applies next-PC priority: halt, taken branch, stall, increment. Takes `jmp` from the branch-decision logic and the branch target from the execute stage. Drives the flush strobes that squash wrong-path instructions in IF/ID and ID/EX.

---
 rtl/pc_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer
// ----------------------------------------------------------------------------
// Program-counter sequencer and branch-flush controller for the pipelined
// core. Owns the fetch PC and picks the next PC with the priority
// halt > taken branch > stall > increment. Drives the flush strobe that
// squashes wrong-path instructions in IF/ID and ID/EX after a taken branch.
//
// Optional feature macro: PC_SEQUENCER_PERF_EN
//   defined   -> taken_cnt / stall_cnt are live saturating 16-bit counters
//   undefined -> taken_cnt / stall_cnt are tied to zero (no counter flops)
//
// Parameters
//   PC_WIDTH      width of pc and target
//   PC_STEP       increment per fetch (byte-addressed 16-bit instructions)
//   RESET_VECTOR  pc value after reset
//   FLUSH_CYCLES  cycles flush stays high per taken branch (1..7)
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   jmp        in   taken-branch/jump decision from execute stage
//   target     in   branch destination, valid when jmp=1
//   stall      in   hazard-unit stall request (load-use)
//   halt_op    in   HALT opcode present in execute stage
//   pc         out  current fetch address (registered)
//   flush      out  squash IF/ID and ID/EX this cycle (combinational)
//   halted     out  core stopped (registered)
//   taken_cnt  out  taken-branch counter
//   stall_cnt  out  stall-cycle counter
// ============================================================================
module pc_sequencer #(
    parameter int                    PC_WIDTH     = 16,
    parameter int                    PC_STEP      = 2,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                    FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                jmp,
    input  logic [PC_WIDTH-1:0] target,
    input  logic                stall,
    input  logic                halt_op,
    output logic [PC_WIDTH-1:0] pc,
    output logic                flush,
    output logic                halted,
    output logic [15:0]         taken_cnt,
    output logic [15:0]         stall_cnt
);

    // FLUSH is entered with the remaining flush cycles after the jmp cycle
    // itself, so the load value is one less than the total flush length.
    localparam logic [2:0]          FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [PC_WIDTH-1:0] PC_INC      = PC_WIDTH'(PC_STEP);
    localparam bit                  MULTI_FLUSH = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } seq_state_t;

    seq_state_t          state;
    seq_state_t          state_next;
    logic [2:0]          fcnt;
    logic [2:0]          fcnt_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                halted_next;
    logic                flush_raw;

    // ------------------------------------------------------------------------
    // State, flush counter, pc and halted registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= RUN;
            fcnt   <= 3'd0;
            pc     <= RESET_VECTOR;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            fcnt   <= fcnt_next;
            pc     <= pc_next;
            halted <= halted_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, next-pc and raw flush decode.
    // In RUN the priority is halt_op > jmp > stall > increment. A jmp that
    // coincides with halt_op is dropped entirely (no target, no flush),
    // and a stall that coincides with a jmp is dropped because the stalled
    // instruction is the one being squashed.
    // In FLUSH, jmp and halt_op come from squashed bubbles and are ignored;
    // only stall still matters for the pc.
    // HALT is terminal until reset.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        fcnt_next   = fcnt;
        pc_next     = pc;
        halted_next = halted;
        flush_raw   = 1'b0;
        pc_inc      = pc + PC_INC;

        case (state)
            RUN: begin
                if (halt_op) begin
                    state_next  = HALT;
                    halted_next = 1'b1;
                end else if (jmp) begin
                    pc_next   = target;
                    flush_raw = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_next = FLUSH;
                        fcnt_next  = FLUSH_LOAD;
                    end
                end else if (!stall) begin
                    pc_next = pc_inc;
                end
            end

            FLUSH: begin
                flush_raw = 1'b1;
                fcnt_next = fcnt - 3'd1;
                if (fcnt == 3'd1) begin
                    state_next = RUN;
                end
                if (!stall) begin
                    pc_next = pc_inc;
                end
            end

            HALT: begin
                halted_next = 1'b1;
            end

            default: begin
                state_next = RUN;
                fcnt_next  = 3'd0;
            end
        endcase
    end

    // Flush is forced low while reset is asserted so a jmp seen during
    // reset never squashes the pipeline.
    assign flush = flush_raw & rst_n;

`ifdef PC_SEQUENCER_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters.
    // A branch counts only when it is accepted (RUN without halt_op).
    // A stall counts only when it actually holds the pc: in RUN that means
    // no halt_op and no jmp overriding it, in FLUSH every stall holds.
    // Neither event can occur in HALT, so the counters freeze there.
    // ------------------------------------------------------------------------
    logic        taken_event;
    logic        stall_event;
    logic [15:0] taken_q;
    logic [15:0] stall_q;

    assign taken_event = (state == RUN) && jmp && !halt_op;
    assign stall_event = stall &&
                         (((state == RUN) && !halt_op && !jmp) ||
                          (state == FLUSH));

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_q <= 16'h0000;
            stall_q <= 16'h0000;
        end else begin
            if (taken_event && (taken_q != 16'hFFFF)) begin
                taken_q <= taken_q + 16'h0001;
            end
            if (stall_event && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'h0001;
            end
        end
    end

    assign taken_cnt = taken_q;
    assign stall_cnt = stall_q;
`else
    assign taken_cnt = 16'h0000;
    assign stall_cnt = 16'h0000;
`endif

endmodule
